// File: rtl/load_store_unit_if.sv
// Shared types and the bundled request / memory-bus / writeback signals of
// the load/store unit. lsu_pkg carries WORD_SIZE and reg_file_op_t so the
// interface, the unit and the register file agree on them.
// master: the core/memory side (issues requests, answers the bus).
// slave : the load/store unit itself.

package lsu_pkg;
    localparam int WORD_SIZE = 32;

    typedef enum logic {
        NO_WRITE       = 1'b0,
        WRITE_REG_DATA = 1'b1
    } reg_file_op_t;
endpackage

interface lsu_if;
    import lsu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_is_store;
    logic [2:0]           req_funct3;
    logic [WORD_SIZE-1:0] req_base;
    logic [WORD_SIZE-1:0] req_offset;
    logic [WORD_SIZE-1:0] req_store_data;
    logic [4:0]           req_rd;

    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    reg_file_op_t         wb_op;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 done;
    logic                 fault;

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_store_data, req_rd, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_op, wb_rd, wb_data, done, fault
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_store_data, req_rd, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_op, wb_rd, wb_data, done, fault
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, one request/acknowledge
// transaction on the data bus, lane steering for stores, alignment and
// extension for loads, single-cycle register-file write per load.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses fault instead of being truncated to access size.

module load_store_unit
    import lsu_pkg::*;
(
    input logic  clock,
    input logic  reset_n,
    lsu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t               state;
    logic [1:0]           lane;
    logic [2:0]           funct3;
    logic                 is_store;
    logic [4:0]           rd;

    logic [WORD_SIZE-1:0] eff_addr;
    logic                 legal_code;
    logic                 misaligned;
    logic                 access_ok;

    // Replicate the store value across every lane it may land in.
    function automatic logic [WORD_SIZE-1:0] store_wdata(input logic [2:0] f3,
                                                         input logic [WORD_SIZE-1:0] sd);
        case (f3[1:0])
            2'b00:   store_wdata = {4{sd[7:0]}};
            2'b01:   store_wdata = {2{sd[15:0]}};
            default: store_wdata = sd;
        endcase
    endfunction

    // Byte enables; a misaligned halfword keeps only addr[1], a word ignores the offset.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_strobe = 4'b0001 << a;
            2'b01:   store_strobe = 4'b0011 << {a[1], 1'b0};
            default: store_strobe = 4'hF;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [WORD_SIZE-1:0] load_extract(input logic [WORD_SIZE-1:0] rdata,
                                                          input logic [2:0] f3,
                                                          input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = rdata[{a[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    load_extract = {{24{b[7]}}, b};
            3'd1:    load_extract = {{16{h[15]}}, h};
            3'd4:    load_extract = {24'd0, b};
            3'd5:    load_extract = {16'd0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    // Effective address and legality of the request currently on the inputs.
    always_comb begin
        eff_addr = bus.req_base + bus.req_offset;
        if (bus.req_is_store)
            legal_code = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
        else
            legal_code = (bus.req_funct3[1:0] != 2'b11) && !(bus.req_funct3[2] && bus.req_funct3[1]);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        access_ok = legal_code && !misaligned;
    end

    assign bus.req_ready = (state == IDLE);

    // Control FSM with all bus and writeback outputs registered.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            lane          <= 2'b00;
            funct3        <= 3'd0;
            is_store      <= 1'b0;
            rd            <= 5'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= 4'h0;
            bus.wb_op     <= NO_WRITE;
            bus.wb_rd     <= 5'd0;
            bus.wb_data   <= '0;
            bus.done      <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lane          <= eff_addr[1:0];
                        funct3        <= bus.req_funct3;
                        is_store      <= bus.req_is_store;
                        rd            <= bus.req_rd;
                        bus.mem_addr  <= {eff_addr[WORD_SIZE-1:2], 2'b00};
                        bus.mem_wdata <= store_wdata(bus.req_funct3, bus.req_store_data);
                        if (access_ok) begin
                            state         <= BUS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_is_store;
                            bus.mem_wstrb <= bus.req_is_store ?
                                             store_strobe(bus.req_funct3, eff_addr[1:0]) : 4'h0;
                        end else begin
                            // Rejected access: report straight away, never touch the bus.
                            state     <= RESP;
                            bus.done  <= 1'b1;
                            bus.fault <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (bus.mem_ack) begin
                        state         <= RESP;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wstrb <= 4'h0;
                        bus.done      <= 1'b1;
                        if (!is_store) begin
                            bus.wb_op   <= WRITE_REG_DATA;
                            bus.wb_rd   <= rd;
                            bus.wb_data <= load_extract(bus.mem_rdata, funct3, lane);
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.fault <= 1'b0;
                    bus.wb_op <= NO_WRITE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes the expected bus
// transaction and the expected completion; a bus responder and a completion
// monitor pop and compare independently.

module tb_load_store_unit;
    import lsu_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    lsu_if bus();

    load_store_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } bus_exp_t;

    typedef struct {
        logic        fault;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_exp_t;

    bus_exp_t    bq[$];
    resp_exp_t   rq[$];
    int          checks = 0;
    int          errors = 0;
    logic        loaded = 1'b0;
    int          wcnt = 0;
    int          req_cycles = 0;
    logic        manual = 1'b0;
    logic        manual_ack = 1'b0;
    logic [31:0] manual_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        bus_exp_t e;
        e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.rdata = rdata; e.waits = waits;
        bq.push_back(e);
    endtask

    task automatic exp_resp(input logic fault, input logic wr, input logic [4:0] rd,
                            input logic [31:0] data);
        resp_exp_t e;
        e.fault = fault; e.wr = wr; e.rd = rd; e.data = data;
        rq.push_back(e);
    endtask

    // Returns at the falling edge of cycle 1 (the accept edge was edge 0).
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) flag("issue_ready_timeout");
        bus.req_valid      = 1'b1;
        bus.req_is_store   = st;
        bus.req_funct3     = f3;
        bus.req_base       = base;
        bus.req_offset     = off;
        bus.req_store_data = sd;
        bus.req_rd         = rd;
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bq.size() == 0 && rq.size() == 0 && bus.req_ready && !loaded) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) flag("wait_idle_timeout");
        @(negedge clock);
    endtask

    // Memory responder: checks each bus request and acknowledges after its wait count.
    initial begin
        bus_exp_t cur;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            if (manual) begin
                bus.mem_ack   = manual_ack;
                bus.mem_rdata = manual_rdata;
                loaded        = 1'b0;
            end else if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                loaded      = 1'b0;
            end else begin
                if (!loaded) begin
                    if (bq.size() == 0) begin
                        flag("unexpected_mem_req");
                        cur = '{addr: bus.mem_addr, we: bus.mem_we, wstrb: bus.mem_wstrb,
                                wdata: bus.mem_wdata, rdata: 32'd0, waits: 0};
                    end else begin
                        cur = bq.pop_front();
                    end
                    loaded     = 1'b1;
                    wcnt       = cur.waits;
                    req_cycles = 0;
                end
                req_cycles++;
                chk("mem_addr", bus.mem_addr, cur.addr);
                chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur.wstrb));
                if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                if (wcnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = cur.rdata;
                end else begin
                    wcnt--;
                    bus.mem_ack = 1'b0;
                end
            end
        end
    end

    // Completion monitor: every done pulse must match the next expected response.
    initial begin
        resp_exp_t e;
        forever begin
            @(negedge clock);
            if (bus.done) begin
                if (rq.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = rq.pop_front();
                    chk("fault", 32'(bus.fault), 32'(e.fault));
                    chk("wb_op", 32'(bus.wb_op == WRITE_REG_DATA), 32'(e.wr));
                    if (e.wr) begin
                        chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                        chk("wb_data", bus.wb_data, e.data);
                    end
                end
            end else if (bus.wb_op == WRITE_REG_DATA) begin
                flag("wb_op_without_done");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n            = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_is_store   = 1'b0;
        bus.req_funct3     = 3'd0;
        bus.req_base       = 32'd0;
        bus.req_offset     = 32'd0;
        bus.req_store_data = 32'd0;
        bus.req_rd         = 5'd0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_wb_op", 32'(bus.wb_op == WRITE_REG_DATA), 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // LW 0x100+4, ack in first bus cycle, with latency checks
        exp_bus(32'h104, 1'b0, 4'h0, 32'd0, 32'hDEADBEEF, 0);
        exp_resp(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h100, 32'd4, 32'd0, 5'd5);
        chk("lw_c1_mem_req", 32'(bus.mem_req), 32'd1);
        chk("lw_c1_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        chk("lw_c2_wb_op", 32'(bus.wb_op == WRITE_REG_DATA), 32'd1);
        chk("lw_c2_done", 32'(bus.done), 32'd1);
        @(negedge clock);
        chk("lw_c3_ready", 32'(bus.req_ready), 32'd1);
        wait_idle();

        // LB / LBU at 0x203
        exp_bus(32'h200, 1'b0, 4'h0, 32'd0, 32'h80FF1234, 0);
        exp_resp(1'b0, 1'b1, 5'd6, 32'hFFFFFF80);
        issue(1'b0, 3'd0, 32'h200, 32'd3, 32'd0, 5'd6);
        wait_idle();
        exp_bus(32'h200, 1'b0, 4'h0, 32'd0, 32'h80FF1234, 0);
        exp_resp(1'b0, 1'b1, 5'd7, 32'h00000080);
        issue(1'b0, 3'd4, 32'h200, 32'd3, 32'd0, 5'd7);
        wait_idle();

        // LH at 0x202 (sign), LHU at 0x100 (zero) with one wait
        exp_bus(32'h200, 1'b0, 4'h0, 32'd0, 32'h80FF1234, 0);
        exp_resp(1'b0, 1'b1, 5'd8, 32'hFFFF80FF);
        issue(1'b0, 3'd1, 32'h200, 32'd2, 32'd0, 5'd8);
        wait_idle();
        exp_bus(32'h100, 1'b0, 4'h0, 32'd0, 32'h12348001, 1);
        exp_resp(1'b0, 1'b1, 5'd9, 32'h00008001);
        issue(1'b0, 3'd5, 32'h100, 32'd0, 32'd0, 5'd9);
        wait_idle();

        // SH at 0x302 with three wait cycles
        exp_bus(32'h300, 1'b1, 4'b1100, 32'hABCDABCD, 32'd0, 3);
        exp_resp(1'b0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 3'd1, 32'h300, 32'd2, 32'h0000ABCD, 5'd0);
        wait_idle();
        chk("sh_req_cycles", 32'(req_cycles), 32'd4);

        // SB at 0x401
        exp_bus(32'h400, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'd0, 0);
        exp_resp(1'b0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 3'd0, 32'h400, 32'd1, 32'h1234565A, 5'd0);
        wait_idle();

        // SW with waits; a request poked while busy must be dropped
        exp_bus(32'h500, 1'b1, 4'hF, 32'h12345678, 32'd0, 5);
        exp_resp(1'b0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 3'd2, 32'h500, 32'd0, 32'h12345678, 5'd0);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd2;
        bus.req_base     = 32'h900;
        bus.req_offset   = 32'd0;
        bus.req_rd       = 5'd20;
        @(negedge clock);
        bus.req_valid = 1'b0;
        wait_idle();

        // Misaligned LW at 0x101 and LH at 0x203
`ifdef LSU_MISALIGN_TRAP_EN
        exp_resp(1'b1, 1'b0, 5'd0, 32'd0);
        issue(1'b0, 3'd2, 32'h100, 32'd1, 32'd0, 5'd10);
        chk("mis_lw_c1_done", 32'(bus.done), 32'd1);
        chk("mis_lw_c1_fault", 32'(bus.fault), 32'd1);
        chk("mis_lw_c1_mem_req", 32'(bus.mem_req), 32'd0);
        wait_idle();
        exp_resp(1'b1, 1'b0, 5'd0, 32'd0);
        issue(1'b0, 3'd1, 32'h200, 32'd3, 32'd0, 5'd11);
        wait_idle();
`else
        exp_bus(32'h100, 1'b0, 4'h0, 32'd0, 32'hCAFEF00D, 0);
        exp_resp(1'b0, 1'b1, 5'd10, 32'hCAFEF00D);
        issue(1'b0, 3'd2, 32'h100, 32'd1, 32'd0, 5'd10);
        wait_idle();
        exp_bus(32'h200, 1'b0, 4'h0, 32'd0, 32'h80FF1234, 0);
        exp_resp(1'b0, 1'b1, 5'd11, 32'hFFFF80FF);
        issue(1'b0, 3'd1, 32'h200, 32'd3, 32'd0, 5'd11);
        wait_idle();
`endif

        // Illegal funct3: load 3 and store 5 fault without bus traffic
        exp_resp(1'b1, 1'b0, 5'd0, 32'd0);
        issue(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 5'd12);
        chk("ill_c1_done", 32'(bus.done), 32'd1);
        chk("ill_c1_fault", 32'(bus.fault), 32'd1);
        chk("ill_c1_mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clock);
        chk("ill_c2_ready", 32'(bus.req_ready), 32'd1);
        wait_idle();
        exp_resp(1'b1, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 3'd5, 32'h100, 32'd0, 32'h11111111, 5'd0);
        wait_idle();

        // Address wrap and load to x0
        exp_bus(32'h4, 1'b0, 4'h0, 32'd0, 32'h11223344, 0);
        exp_resp(1'b0, 1'b1, 5'd13, 32'h11223344);
        issue(1'b0, 3'd2, 32'hFFFFFFFC, 32'd8, 32'd0, 5'd13);
        wait_idle();
        exp_bus(32'h800, 1'b0, 4'h0, 32'd0, 32'h55AA55AA, 0);
        exp_resp(1'b0, 1'b1, 5'd0, 32'h55AA55AA);
        issue(1'b0, 3'd2, 32'h800, 32'd0, 32'd0, 5'd0);
        wait_idle();

        // Reset during a bus wait, then a late ack in IDLE
        exp_bus(32'h700, 1'b0, 4'h0, 32'd0, 32'd0, 20);
        issue(1'b0, 3'd2, 32'h700, 32'd0, 32'd0, 5'd14);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_mem_addr", bus.mem_addr, 32'd0);
        reset_n      = 1'b1;
        manual_rdata = 32'hFFFFFFFF;
        manual_ack   = 1'b1;
        manual       = 1'b1;
        repeat (2) @(negedge clock);
        chk("late_ack_done", 32'(bus.done), 32'd0);
        manual     = 1'b0;
        manual_ack = 1'b0;
        @(negedge clock);
        wait_idle();
        exp_bus(32'h104, 1'b0, 4'h0, 32'd0, 32'hA5A50001, 0);
        exp_resp(1'b0, 1'b1, 5'd15, 32'hA5A50001);
        issue(1'b0, 3'd2, 32'h100, 32'd4, 32'd0, 5'd15);
        wait_idle();

        chk("bus_queue_empty", 32'(bq.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
